pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects, FSM states, stage bit positions.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_MEM_ALU = 2'b01;
    localparam logic [1:0] FWD_MEM_LD  = 2'b10;
    localparam logic [1:0] FWD_WB      = 2'b11;

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_FLUSH = 2'b01;
    localparam logic [1:0] ST_HALT  = 2'b10;

    // Bit positions inside stage_en / stage_rst, ordered {wb,mem,exe,id,if}
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EXE = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    typedef logic [4:0] stage_vec_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Forward-select for one EXE operand: MEM result beats WB result, register 0 is never forwarded.
// Purely combinational, no state.
module pipe_hazard_ctrl_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src_addr,
    input  logic          mem_wen,
    input  logic [AW-1:0] mem_waddr,
    input  logic          mem_mem_ren,
    input  logic          wb_wen,
    input  logic [AW-1:0] wb_waddr,
    output logic [1:0]    fwd_sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_wen && (mem_waddr == src_addr) && (src_addr != '0);
    assign wb_hit  = wb_wen  && (wb_waddr  == src_addr) && (src_addr != '0);

    always_comb begin
        fwd_sel = FWD_RF;
        if (mem_hit) begin
            fwd_sel = mem_mem_ren ? FWD_MEM_LD : FWD_MEM_ALU;
        end else if (wb_hit) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard control: operand forwarding, load-use stall, branch squash, perf counters.
// Optional single-step debug halt when PIPE_HAZARD_DEBUG_EN is defined (adds debug_en / debug_step).
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int AW         = 5,
    parameter int BR_PENALTY = 3,
    parameter int CW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] id_rs_addr,
    input  logic [AW-1:0] id_rt_addr,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic          id_is_branch,
    input  logic [AW-1:0] exe_rs_addr,
    input  logic [AW-1:0] exe_rt_addr,
    input  logic          exe_wen,
    input  logic [AW-1:0] exe_waddr,
    input  logic          exe_mem_ren,
    input  logic          mem_wen,
    input  logic [AW-1:0] mem_waddr,
    input  logic          mem_mem_ren,
    input  logic          wb_wen,
    input  logic [AW-1:0] wb_waddr,
`ifdef PIPE_HAZARD_DEBUG_EN
    input  logic          debug_en,
    input  logic          debug_step,
`endif
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic [4:0]    stage_en,
    output logic [4:0]    stage_rst,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    localparam logic [1:0] BR_LOAD = 2'(BR_PENALTY);

    logic [1:0] sel_a;
    logic [1:0] sel_b;

    pipe_hazard_ctrl_fwd_unit #(.AW(AW)) u_fwd_a (
        .src_addr    (exe_rs_addr),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .mem_mem_ren (mem_mem_ren),
        .wb_wen      (wb_wen),
        .wb_waddr    (wb_waddr),
        .fwd_sel     (sel_a)
    );

    pipe_hazard_ctrl_fwd_unit #(.AW(AW)) u_fwd_b (
        .src_addr    (exe_rt_addr),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .mem_mem_ren (mem_mem_ren),
        .wb_wen      (wb_wen),
        .wb_waddr    (wb_waddr),
        .fwd_sel     (sel_b)
    );

    assign fwd_a = rst ? FWD_RF : sel_a;
    assign fwd_b = rst ? FWD_RF : sel_b;

    logic load_use;

    assign load_use = exe_mem_ren && exe_wen && (exe_waddr != '0) &&
                      ((id_rs_used && (id_rs_addr == exe_waddr)) ||
                       (id_rt_used && (id_rt_addr == exe_waddr)));

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [1:0] work_state;
    logic [1:0] work_next;
    logic [1:0] flush_left_q;
    logic [1:0] flush_left_d;
    logic       adv;

`ifdef PIPE_HAZARD_DEBUG_EN
    logic       step_q;
    logic       step_prev_q;
    logic [1:0] resume_q;

    // While halted the pipeline runs only on the cycle after a step edge, using the state saved on entry
    assign adv        = (state_q != ST_HALT) || (step_q && !step_prev_q);
    assign work_state = (state_q == ST_HALT) ? resume_q : state_q;
    assign state_d    = debug_en ? ST_HALT : work_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q      <= 1'b0;
            step_prev_q <= 1'b0;
            resume_q    <= ST_RUN;
        end else begin
            step_q      <= debug_step;
            step_prev_q <= step_q;
            resume_q    <= work_next;
        end
    end
`else
    assign adv        = 1'b1;
    assign work_state = state_q;
    assign state_d    = work_next;
`endif

    stage_vec_t en_v;
    stage_vec_t rst_v;
    logic       stall_inc;
    logic       flush_inc;

    always_comb begin
        work_next    = work_state;
        flush_left_d = flush_left_q;
        en_v         = '1;
        rst_v        = '0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (!adv) begin
            en_v = '0;
        end else begin
            if (load_use) begin
                en_v[STG_IF]   = 1'b0;
                en_v[STG_ID]   = 1'b0;
                rst_v[STG_EXE] = 1'b1;
                stall_inc      = 1'b1;
            end
            // A stall takes priority: a branch waits in ID, a flush freezes its countdown
            case (work_state)
                ST_FLUSH: begin
                    if (!load_use) begin
                        rst_v[STG_ID] = 1'b1;
                        flush_inc     = 1'b1;
                        flush_left_d  = flush_left_q - 2'd1;
                        if (flush_left_q <= 2'd1) begin
                            work_next = ST_RUN;
                        end
                    end
                end
                default: begin
                    if (id_is_branch && !load_use) begin
                        work_next    = ST_FLUSH;
                        flush_left_d = BR_LOAD;
                    end
                end
            endcase
        end
    end

    assign stage_en  = rst ? 5'b11111 : en_v;
    assign stage_rst = rst ? 5'b11111 : rst_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            flush_left_q <= 2'd0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule
